// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the NOP encoding and the fetch-stage state type.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_t;

  // Misaligned, or the last byte of the word lies beyond the memory. The sum
  // is 65 bits wide, so a PC near 2^64 cannot wrap into the valid range.
  function automatic logic fetch_addr_bad(input logic [ADDR_W-1:0] pc,
                                          input logic [ADDR_W:0]   limit);
    logic [ADDR_W:0] last_byte;
    last_byte = {1'b0, pc} + 65'd3;
    return (pc[1:0] != 2'b00) || (last_byte >= limit);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Control, instruction-memory and IF/ID signals between the fetch stage and its surroundings.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic               stall;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               ifid_valid;
  logic [ADDR_W-1:0]  ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               fault;
  logic [ADDR_W-1:0]  fault_pc;
  logic [31:0]        fetch_count;

  // Fetch stage side.
  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, ifid_valid, ifid_pc, ifid_instr, fault, fault_pc, fetch_count
  );

  // Pipeline control and instruction memory side.
  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, ifid_valid, ifid_pc, ifid_instr, fault, fault_pc, fetch_count
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, combinational ROM address, IF/ID register, fault
// capture and a saturating delivered-instruction counter.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                IMEM_SIZE = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC  = 64'd0
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_fetch_if.master bus
);

  localparam logic [ADDR_W:0] IMEM_LIMIT = 65'(IMEM_SIZE);

  fetch_state_t       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic               ifid_valid_reg;
  logic [ADDR_W-1:0]  ifid_pc_reg;
  logic [INSTR_W-1:0] ifid_instr_reg;
  logic [ADDR_W-1:0]  fault_pc_reg;
  logic [31:0]        fetch_count_reg;

  logic pc_bad;
  logic capture;
  logic flush;
  logic enter_fault;

  assign pc_bad = fetch_addr_bad(pc_reg, IMEM_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= FETCH_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Redirect outranks the FAULT hold and stall; a bad PC is only ever
  // discovered in RUN, and its memory word is never captured.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    capture     = 1'b0;
    flush       = 1'b0;
    enter_fault = 1'b0;
    if (bus.redirect) begin
      state_next = FETCH_RUN;
      pc_next    = bus.redirect_pc;
      flush      = 1'b1;
    end else if (state_reg == FETCH_FAULT) begin
      state_next = FETCH_FAULT;
    end else if (bus.stall) begin
      state_next = state_reg;
    end else if (pc_bad) begin
      state_next  = FETCH_FAULT;
      flush       = 1'b1;
      enter_fault = 1'b1;
    end else begin
      pc_next = pc_reg + 64'd4;
      capture = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ifid_valid_reg  <= 1'b0;
      ifid_pc_reg     <= '0;
      ifid_instr_reg  <= NOP_INSTR;
      fault_pc_reg    <= '0;
      fetch_count_reg <= '0;
    end else begin
      if (capture) begin
        ifid_valid_reg <= 1'b1;
        ifid_pc_reg    <= pc_reg;
        ifid_instr_reg <= bus.imem_instr;
        if (fetch_count_reg != 32'hFFFF_FFFF) begin
          fetch_count_reg <= fetch_count_reg + 32'd1;
        end
      end else if (flush) begin
        ifid_valid_reg <= 1'b0;
        ifid_instr_reg <= NOP_INSTR;
      end
      if (enter_fault) begin
        fault_pc_reg <= pc_reg;
      end
    end
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.ifid_valid  = ifid_valid_reg;
  assign bus.ifid_pc     = ifid_pc_reg;
  assign bus.ifid_instr  = ifid_instr_reg;
  assign bus.fault       = (state_reg == FETCH_FAULT);
  assign bus.fault_pc    = fault_pc_reg;
  assign bus.fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios followed by random
// stall/redirect/reset traffic, checked against a per-edge behavioural model.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int IMEM_BYTES = 1024;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_item_t;

  logic clk;
  logic reset_n;
  instr_fetch_if bus ();

  instr_fetch #(
    .IMEM_SIZE (IMEM_BYTES),
    .RESET_PC  (64'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  logic [31:0] rom [256];
  assign bus.imem_instr = (bus.imem_addr < 64'(IMEM_BYTES)) ? rom[bus.imem_addr[9:2]] : 32'hBAD0_BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  fetch_item_t sb[$];

  // Reference state, updated once per rising edge from the sampled inputs.
  logic [63:0] m_pc;
  logic        m_fault;
  logic [63:0] m_fault_pc;
  logic        m_valid;
  logic [63:0] m_ifid_pc;
  logic [31:0] m_instr;
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_bad(input logic [63:0] pc);
    // Last byte pc+3 must be < size, i.e. pc <= size-4; written this way it cannot overflow.
    return (pc % 4 != 0) || (pc > 64'(IMEM_BYTES - 4));
  endfunction

  always @(posedge clk) begin
    fetch_item_t it;
    if (!reset_n) begin
      m_pc = 64'd0; m_fault = 1'b0; m_fault_pc = 64'd0;
      m_valid = 1'b0; m_ifid_pc = 64'd0; m_instr = NOP_INSTR; m_count = 32'd0;
    end else if (bus.redirect) begin
      m_pc = bus.redirect_pc; m_valid = 1'b0; m_instr = NOP_INSTR; m_fault = 1'b0;
    end else if (m_fault || bus.stall) begin
      // nothing moves
    end else if (model_bad(m_pc)) begin
      m_fault = 1'b1; m_fault_pc = m_pc; m_valid = 1'b0; m_instr = NOP_INSTR;
    end else begin
      it.pc = m_pc;
      it.instr = rom[m_pc / 4];
      sb.push_back(it);
      m_valid = 1'b1; m_ifid_pc = m_pc; m_instr = it.instr;
      m_pc = m_pc + 64'd4;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end
  end

  // Monitor: per-edge status compare plus scoreboard pop on each new delivery.
  always @(posedge clk) begin
    fetch_item_t exp_it;
    logic fresh;
    #1;
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("fault", 64'(bus.fault), 64'(m_fault));
    chk("fault_pc", bus.fault_pc, m_fault_pc);
    chk("ifid_valid", 64'(bus.ifid_valid), 64'(m_valid));
    chk("ifid_instr", 64'(bus.ifid_instr), 64'(m_instr));
    chk("fetch_count", 64'(bus.fetch_count), 64'(m_count));
    if (!reset_n) chk("reset_ifid_pc", bus.ifid_pc, 64'd0);
    fresh = reset_n && bus.ifid_valid && !(bus.stall && !bus.redirect);
    if (fresh) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery: got pc %h instr %h expected none", bus.ifid_pc, bus.ifid_instr);
      end else begin
        exp_it = sb.pop_front();
        chk("deliver_pc", bus.ifid_pc, exp_it.pc);
        chk("deliver_instr", 64'(bus.ifid_instr), 64'(exp_it.instr));
        $display("fetch pc=%h instr=%h count=%0d", bus.ifid_pc, bus.ifid_instr, bus.fetch_count);
      end
    end else if (m_valid) begin
      chk("held_ifid_pc", bus.ifid_pc, m_ifid_pc);
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [63:0] t);
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = t;
    @(negedge clk);
  endtask

  function automatic logic [63:0] rand_target();
    case ($urandom_range(0, 4))
      0: return 64'($urandom_range(0, 255)) * 64'd4;
      1: return 64'(IMEM_BYTES) - 64'd4 * 64'($urandom_range(0, 4));
      2: return 64'($urandom_range(0, 1023)) | 64'd1;
      3: return 64'hFFFF_FFFF_FFFF_FFFC;
      default: return 64'($urandom_range(0, 15)) * 64'd4 + 64'd2;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    reset_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    // sequential fetch, then stall with PC at 8
    repeat (2) cyc(1'b0, 1'b0, 64'd0);
    repeat (3) cyc(1'b1, 1'b0, 64'd0);
    repeat (2) cyc(1'b0, 1'b0, 64'd0);
    // redirect together with stall at PC 0x10
    cyc(1'b1, 1'b1, 64'h40);
    repeat (3) cyc(1'b0, 1'b0, 64'd0);
    // run off the end of memory, sit in FAULT, then recover
    cyc(1'b0, 1'b1, 64'd1000);
    repeat (8) cyc(1'b0, 1'b0, 64'd0);
    cyc(1'b1, 1'b0, 64'd0);
    repeat (2) cyc(1'b0, 1'b0, 64'd0);
    cyc(1'b0, 1'b1, 64'd0);
    repeat (3) cyc(1'b0, 1'b0, 64'd0);
    // misaligned redirect, then reset while faulted
    cyc(1'b0, 1'b1, 64'd6);
    repeat (3) cyc(1'b0, 1'b0, 64'd0);
    reset_n = 1'b0;
    cyc(1'b0, 1'b0, 64'd0);
    reset_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 64'd0);
    // overflowing target near 2^64
    cyc(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (2) cyc(1'b0, 1'b0, 64'd0);
    // random traffic
    for (int n = 0; n < 500; n++) begin
      reset_n = ($urandom_range(0, 99) >= 2);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rand_target());
    end
    reset_n = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 64'd0);
    chk("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
